// File: rtl/slos_gen_multi_if.sv
//------------------------------------------------------------------------------
// Module      : slos_gen_multi_if
// Description : Control/status bundle for the multi-lane SLOS set generator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface slos_gen_multi_if #(
  parameter int LANES = 2
);
  logic             start;
  logic [15:0]      num_sets;
  logic             slos_sel;
  logic             stop;
  logic [LANES-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             set_done;
  logic             done;
  logic [15:0]      set_cnt;

  modport master (
    output start, num_sets, slos_sel, stop,
    input  data_out, valid, busy, set_done, done, set_cnt
  );

  modport slave (
    input  start, num_sets, slos_sel, stop,
    output data_out, valid, busy, set_done, done, set_cnt
  );
endinterface

`default_nettype wire

// File: rtl/slos_gen_multi.sv
//------------------------------------------------------------------------------
// Module      : slos_gen_multi
// Description : LFSR-based SLOS1/SLOS2 set generator driving LANES serial lanes.
//               Optional macro SLOS_GEN_CNT_EN exposes the completed-set count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module slos_gen_multi #(
  parameter int                      LANES  = 2,
  parameter int                      LFSR_W = 11,
  parameter int                      TAP    = 9,
  parameter logic [LANES*LFSR_W-1:0] SEEDS  = {11'h0a3, 11'h400}
) (
  input wire logic        clk,
  input wire logic        reset,
  slos_gen_multi_if.slave bus
);

  localparam logic [LFSR_W-1:0] C_LAST_BIT = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           r_state;
  logic [LFSR_W-1:0] r_bit_idx;
  logic [15:0]      r_num_sets;
  logic [15:0]      r_sets;
  logic             r_sel;
  logic             r_stop;
  logic             r_last;
  logic [LANES-1:0] r_data;
  logic             r_valid;
  logic             r_set_done;
  logic             r_done;

  logic             w_advance;
  logic             w_set_end;
  logic             w_final;
  logic [LANES-1:0] w_lane_bit;

  // r_last marks the drain cycle that holds the final bit before IDLE
  assign w_advance = (r_state == SEND) && !r_last;
  assign w_set_end = (r_bit_idx == C_LAST_BIT);
  assign w_final   = w_set_end &&
                     (r_stop || bus.stop ||
                      ((r_num_sets != 16'd0) && ((r_sets + 16'd1) == r_num_sets)));

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [LFSR_W-1:0] C_SEED = SEEDS[gi*LFSR_W +: LFSR_W];
    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_lfsr <= C_SEED;
      end else if (w_advance) begin
        if (w_set_end) begin
          r_lfsr <= C_SEED;
        end else begin
          r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_W-1] ^ r_lfsr[TAP-1]};
        end
      end
    end

    assign w_lane_bit[gi] = r_lfsr[0] ^ r_sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_bit_idx  <= '0;
      r_num_sets <= 16'd0;
      r_sets     <= 16'd0;
      r_sel      <= 1'b0;
      r_stop     <= 1'b0;
      r_last     <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_set_done <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_data     <= '0;
          r_valid    <= 1'b0;
          r_set_done <= 1'b0;
          r_done     <= 1'b0;
          if (bus.start) begin
            r_state    <= SEND;
            r_bit_idx  <= '0;
            r_num_sets <= bus.num_sets;
            r_sel      <= bus.slos_sel;
            r_stop     <= bus.stop;
            r_sets     <= 16'd0;
            r_last     <= 1'b0;
          end
        end
        SEND: begin
          if (r_last) begin
            r_state    <= IDLE;
            r_last     <= 1'b0;
            r_stop     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_set_done <= 1'b0;
            r_done     <= 1'b0;
          end else begin
            r_data     <= w_lane_bit;
            r_valid    <= 1'b1;
            r_set_done <= w_set_end;
            r_done     <= w_final;
            r_bit_idx  <= r_bit_idx + 1'b1;
            if (bus.stop) begin
              r_stop <= 1'b1;
            end
            // counter wraps freely; only a nonzero num_sets compares against it
            if (w_set_end) begin
              r_sets <= r_sets + 16'd1;
              r_last <= w_final;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_out = r_data;
  assign bus.valid    = r_valid;
  assign bus.busy     = (r_state != IDLE);
  assign bus.set_done = r_set_done;
  assign bus.done     = r_done;

`ifdef SLOS_GEN_CNT_EN
  assign bus.set_cnt = r_sets;
`else
  assign bus.set_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slos_gen_multi.sv
//------------------------------------------------------------------------------
// Module      : tb_slos_gen_multi
// Description : Directed self-checking bench for slos_gen_multi (default and 4-lane builds).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_slos_gen_multi;

  localparam logic [10:0] SEED0   = 11'h400;
  localparam logic [10:0] SEED1   = 11'h0a3;
  localparam logic [19:0] B_SEEDS = {5'h15, 5'h0a, 5'h1f, 5'h01};

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] first_set [2048];

  always #5 clk = ~clk;

  slos_gen_multi_if #(.LANES(2)) ifa ();
  slos_gen_multi_if #(.LANES(4)) ifb ();

  slos_gen_multi dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  slos_gen_multi #(
    .LANES  (4),
    .LFSR_W (5),
    .TAP    (3),
    .SEEDS  (B_SEEDS)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef SLOS_GEN_CNT_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_a(input string tag);
    checks++;
    if (ifa.data_out !== 2'b00 || ifa.valid !== 1'b0 || ifa.busy !== 1'b0 ||
        ifa.set_done !== 1'b0 || ifa.done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got data=%b valid=%b busy=%b set_done=%b done=%b, expected all 0",
               tag, ifa.data_out, ifa.valid, ifa.busy, ifa.set_done, ifa.done);
    end
  endtask

  task automatic do_start_a(input logic [15:0] n, input logic sel, input logic with_stop);
    ifa.start = 1'b1; ifa.num_sets = n; ifa.slos_sel = sel; ifa.stop = with_stop;
    tick();
    // scramble the sampled inputs to show they were latched
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.num_sets = 16'hdead; ifa.slos_sel = ~sel;
    checks++;
    if (ifa.busy !== 1'b1 || ifa.valid !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: got busy=%b valid=%b, expected busy=1 valid=0", ifa.busy, ifa.valid);
    end
  endtask

  // stop_at/restart_at/abort_at: bit index at whose edge the event applies, -1 = none
  task automatic run_set_a(input logic sel, input int set_no, input bit is_final,
                           input int stop_at, input int restart_at, input int abort_at,
                           input bit store, input bit cmp_first);
    logic [10:0] s0, s1;
    logic [1:0]  exp;
    logic [2:0]  lane0_head;
    s0 = SEED0; s1 = SEED1;
    lane0_head = 3'b010;
    for (int k = 0; k < 2048; k++) begin
      if (k == stop_at) ifa.stop = 1'b1;
      if (k == restart_at) begin
        ifa.start = 1'b1; ifa.num_sets = 16'd7; ifa.slos_sel = ~sel;
      end
      tick();
      ifa.stop = 1'b0; ifa.start = 1'b0;
      exp = {s1[0] ^ sel, s0[0] ^ sel};
      checks++;
      if (ifa.data_out !== exp) begin
        errors++;
        $display("FAIL data_out set%0d bit%0d: got %b expected %b", set_no, k, ifa.data_out, exp);
      end
      if (k < 3) begin
        checks++;
        if (ifa.data_out[0] !== (lane0_head[2-k] ^ sel)) begin
          errors++;
          $display("FAIL lane0_head bit%0d: got %b expected %b", k, ifa.data_out[0], lane0_head[2-k] ^ sel);
        end
      end
      if (k == 0) begin
        checks++;
        if (ifa.data_out[1] !== (1'b1 ^ sel)) begin
          errors++;
          $display("FAIL lane1_head: got %b expected %b", ifa.data_out[1], 1'b1 ^ sel);
        end
        checks++;
        if (ifa.set_cnt !== exp_cnt(set_no - 1)) begin
          errors++;
          $display("FAIL set_cnt_start set%0d: got %0d expected %0d", set_no, ifa.set_cnt, exp_cnt(set_no - 1));
        end
      end
      checks++;
      if (ifa.valid !== 1'b1 || ifa.busy !== 1'b1) begin
        errors++;
        $display("FAIL valid_busy set%0d bit%0d: got valid=%b busy=%b expected 1 1", set_no, k, ifa.valid, ifa.busy);
      end
      checks++;
      if (ifa.set_done !== (k == 2047) || ifa.done !== (k == 2047 && is_final)) begin
        errors++;
        $display("FAIL pulses set%0d bit%0d: got set_done=%b done=%b expected %b %b",
                 set_no, k, ifa.set_done, ifa.done, (k == 2047), (k == 2047 && is_final));
      end
      if (k == 2047) begin
        checks++;
        if (ifa.set_cnt !== exp_cnt(set_no)) begin
          errors++;
          $display("FAIL set_cnt_end set%0d: got %0d expected %0d", set_no, ifa.set_cnt, exp_cnt(set_no));
        end
      end
      if (store) first_set[k] = ifa.data_out;
      if (cmp_first) begin
        checks++;
        if (ifa.data_out !== first_set[k]) begin
          errors++;
          $display("FAIL repeat_set bit%0d: got %b expected %b", k, ifa.data_out, first_set[k]);
        end
      end
      if (k == abort_at) break;
      s0 = {s0[9:0], s0[10] ^ s0[8]};
      s1 = {s1[9:0], s1[10] ^ s1[8]};
    end
  endtask

  task automatic test_reset();
    #12;
    check_idle_a("reset_idle");
    checks++;
    if (ifa.set_cnt !== 16'd0 || ifb.busy !== 1'b0 || ifb.data_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_misc: got set_cnt=%0d b_busy=%b b_data=%b expected 0 0 0", ifa.set_cnt, ifb.busy, ifb.data_out);
    end
    reset = 1'b1;
    tick();
    check_idle_a("post_reset_idle");
  endtask

  task automatic test_single_slos1();
    do_start_a(16'd1, 1'b0, 1'b0);
    run_set_a(1'b0, 1, 1'b1, -1, -1, -1, 1'b0, 1'b0);
    tick();
    check_idle_a("single_end_idle");
    checks++;
    if (ifa.set_cnt !== exp_cnt(1)) begin
      errors++;
      $display("FAIL single_set_cnt: got %0d expected %0d", ifa.set_cnt, exp_cnt(1));
    end
  endtask

  task automatic test_slos2_two_sets();
    do_start_a(16'd2, 1'b1, 1'b0);
    run_set_a(1'b1, 1, 1'b0, -1, -1, -1, 1'b1, 1'b0);
    run_set_a(1'b1, 2, 1'b1, -1, -1, -1, 1'b0, 1'b1);
    tick();
    check_idle_a("slos2_end_idle");
  endtask

  task automatic test_stop_continuous();
    do_start_a(16'd0, 1'b0, 1'b0);
    run_set_a(1'b0, 1, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    run_set_a(1'b0, 2, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    run_set_a(1'b0, 3, 1'b1, 100, -1, -1, 1'b0, 1'b0);
    tick();
    check_idle_a("stop_end_idle");
    checks++;
    if (ifa.set_cnt !== exp_cnt(3)) begin
      errors++;
      $display("FAIL stop_set_cnt: got %0d expected %0d", ifa.set_cnt, exp_cnt(3));
    end
  endtask

  task automatic test_restart_and_boundary_stop();
    do_start_a(16'd2, 1'b0, 1'b0);
    run_set_a(1'b0, 1, 1'b0, -1, 500, -1, 1'b0, 1'b0);
    run_set_a(1'b0, 2, 1'b1, 2047, -1, -1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_a("boundary_end_idle");
    end
  endtask

  task automatic test_start_stop_idle();
    do_start_a(16'd0, 1'b1, 1'b1);
    run_set_a(1'b1, 1, 1'b1, -1, -1, -1, 1'b0, 1'b0);
    tick();
    check_idle_a("start_stop_end_idle");
  endtask

  task automatic test_reset_mid();
    do_start_a(16'd0, 1'b0, 1'b0);
    run_set_a(1'b0, 1, 1'b0, -1, -1, 500, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_idle_a("async_reset_idle");
    checks++;
    if (ifa.set_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset_cnt: got %0d expected 0", ifa.set_cnt);
    end
    tick();
    check_idle_a("reset_hold_idle");
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_a("no_autorestart_idle");
    end
    do_start_a(16'd1, 1'b0, 1'b0);
    run_set_a(1'b0, 1, 1'b1, -1, -1, -1, 1'b0, 1'b0);
    tick();
    check_idle_a("reset_restart_end_idle");
  endtask

  task automatic test_lanes4();
    logic [4:0] s [4];
    logic [3:0] exp;
    ifb.start = 1'b1; ifb.num_sets = 16'd3; ifb.slos_sel = 1'b0; ifb.stop = 1'b0;
    tick();
    ifb.start = 1'b0; ifb.num_sets = 16'd0; ifb.slos_sel = 1'b1;
    for (int set = 1; set <= 3; set++) begin
      for (int l = 0; l < 4; l++) s[l] = B_SEEDS[l*5 +: 5];
      for (int k = 0; k < 32; k++) begin
        tick();
        for (int l = 0; l < 4; l++) exp[l] = s[l][0];
        checks++;
        if (ifb.data_out !== exp || ifb.valid !== 1'b1) begin
          errors++;
          $display("FAIL lanes4_data set%0d bit%0d: got %b valid=%b expected %b valid=1",
                   set, k, ifb.data_out, ifb.valid, exp);
        end
        checks++;
        if (ifb.set_done !== (k == 31) || ifb.done !== (k == 31 && set == 3)) begin
          errors++;
          $display("FAIL lanes4_pulses set%0d bit%0d: got set_done=%b done=%b expected %b %b",
                   set, k, ifb.set_done, ifb.done, (k == 31), (k == 31 && set == 3));
        end
        for (int l = 0; l < 4; l++) s[l] = {s[l][3:0], s[l][4] ^ s[l][2]};
      end
    end
    tick();
    checks++;
    if (ifb.busy !== 1'b0 || ifb.valid !== 1'b0 || ifb.data_out !== 4'd0 || ifb.set_cnt !== exp_cnt(3)) begin
      errors++;
      $display("FAIL lanes4_end: got busy=%b valid=%b data=%b set_cnt=%0d expected 0 0 0000 %0d",
               ifb.busy, ifb.valid, ifb.data_out, ifb.set_cnt, exp_cnt(3));
    end
  endtask

  initial begin
    ifa.start = 1'b0; ifa.num_sets = 16'd0; ifa.slos_sel = 1'b0; ifa.stop = 1'b0;
    ifb.start = 1'b0; ifb.num_sets = 16'd0; ifb.slos_sel = 1'b0; ifb.stop = 1'b0;
    test_reset();
    test_single_slos1();
    test_slos2_two_sets();
    test_stop_continuous();
    test_restart_and_boundary_stop();
    test_start_stop_idle();
    test_reset_mid();
    test_lanes4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/slos_gen_multi.md
SLOS_GEN_MULTI -- requirements
Module: slos_gen_multi

Interface
REQ-001 Parameter LANES, default 2: number of independent serial lanes, legal range 1..4.
REQ-002 Parameter LFSR_W, default 11: LFSR width; a set is 2^LFSR_W bits.
REQ-003 Parameter TAP, default 9: second feedback tap; feedback = reg[LFSR_W-1] ^ reg[TAP-1].
REQ-004 Parameter SEEDS, default {11'h0a3, 11'h400}: packed LANES*LFSR_W; lane i seed = SEEDS[i*LFSR_W +: LFSR_W].
REQ-005 Clock and reset: clk input 1 system clock, rising edge; reset input 1 asynchronous, active-low.
REQ-006 start input 1: one-cycle request to begin transmission, sampled only in IDLE.
REQ-007 num_sets input 16: number of sets to send, latched at start; 0 means continuous.
REQ-008 slos_sel input 1: set type, latched at start; 0 = SLOS1, 1 = SLOS2.
REQ-009 stop input 1: request to end transmission at the next set boundary.
REQ-010 data_out output LANES: registered serial bit per lane.
REQ-011 valid output 1: data_out carries set bits.
REQ-012 busy output 1: FSM not in IDLE.
REQ-013 set_done output 1: one-cycle pulse coincident with the last bit of every set.
REQ-014 done output 1: one-cycle pulse coincident with the last bit of the final set.
REQ-015 set_cnt output 16: number of completed sets, per REQ-034.

Function
REQ-016 FSM states: IDLE and SEND.
REQ-017 Transitions: IDLE->SEND on start; SEND->IDLE after the final set's last bit.
REQ-018 Latency: start sampled high at edge t; first set bit on data_out, with valid=1, after edge t+1.
REQ-019 Bit index k runs 0..2^LFSR_W-1 from a counter; set boundaries never depend on LFSR state compare.
REQ-020 Lane state at k=0 equals its seed.
REQ-021 Each later bit: state <= {state[LFSR_W-2:0], feedback}.
REQ-022 After k=2^LFSR_W-1, every lane state reloads its seed for the next set.
REQ-023 Lane bit is state[0] for SLOS1 and ~state[0] for SLOS2; all lanes share k and slos_sel.
REQ-024 Final set: the set whose count equals num_sets (nonzero num_sets), or the set in progress when stop has been seen.
REQ-025 stop is latched; stop at the last bit of a set makes that set final.
REQ-026 Finite num_sets ending and stop in the same cycle produce one done pulse only.
REQ-027 start in SEND is ignored; num_sets and slos_sel are not re-sampled.
REQ-028 In IDLE: data_out=0, valid=0, set_done=0, done=0.
REQ-029 start and stop together in IDLE: send exactly one set.
REQ-030 The internal set counter wraps from 16'hFFFF to 0 in continuous mode without terminating.

Reset
REQ-031 Asserted reset immediately forces IDLE and sets all outputs and the set counter to 0.
REQ-032 Reset mid-set aborts the set with no done pulse; the next set starts only after a new start.
REQ-033 All LFSR states load their seeds on reset.

Configuration
REQ-034 Macro SLOS_GEN_CNT_EN: when defined, set_cnt shows completed sets since the last start, cleared on start; when undefined, set_cnt is tied to 0 and the port remains.

Verification
REQ-035 Defaults, start with num_sets=1, slos_sel=0: lane0 first bits 0,1,0; lane1 starts with 1; valid for 2048 cycles; set_done and done together at bit 2047.
REQ-036 slos_sel=1, num_sets=2: lane0 bits inverted (1,0,1...); set_done at bits 2047 and 4095; done only at 4095; second set bit-identical to first.
REQ-037 num_sets=0, stop pulsed at bit 100 of set 3: transmission ends at set 3 bit 2047 with one done pulse; set_cnt=3 with SLOS_GEN_CNT_EN, 0 without.
REQ-038 Start re-pulsed mid-set, and stop at bit 2047 of set 2 of 2: both have no extra effect; single done.
REQ-039 Reset asserted at bit 500: outputs 0 immediately, no done; next start restarts lane0 at seed 0x400.
REQ-040 LANES=4, LFSR_W=5, TAP=3: 32-bit sets; each lane matches a reference model over 3 sets.
